// File: rtl/gsim_solver.sv
// Gauss-Seidel solver for the banded (20, -13, 6, -1) system: receive b, run sweeps in place, stream x.
// Define GSIM_CONVERGE_EN to end CALC early once a full sweep changes no x_i by more than TOL.
module gsim_solver #(
  parameter int N      = 16,
  parameter int BW     = 16,
  parameter int XW     = 32,
  parameter int FW     = 16,
  parameter int ITER_W = 8,
  parameter int TOL    = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_en,
  input  logic signed [BW-1:0] b_in,
  input  logic [ITER_W-1:0]    iter_num,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XW-1:0]        x_out,
  output logic [ITER_W-1:0]    sweeps
);

  localparam int IW = $clog2(N);
  localparam int AW = XW + 8;

  localparam logic [1:0] S_RECEIVE = 2'd0;
  localparam logic [1:0] S_CALC    = 2'd1;
  localparam logic [1:0] S_SEND    = 2'd2;

  localparam logic signed [XW-1:0] X_ONE  = XW'(1) << FW;
  localparam logic signed [AW-1:0] K1     = AW'(1);
  localparam logic signed [AW-1:0] K6     = AW'(6);
  localparam logic signed [AW-1:0] K13    = AW'(13);
  localparam logic signed [AW-1:0] K20    = AW'(20);
  localparam logic signed [AW-1:0] SAT_HI = {{9{1'b0}}, {(XW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_LO = {{9{1'b1}}, {(XW-1){1'b0}}};

  if (N < 4 || N > 64 || XW <= FW + 8 || TOL < 0) begin : g_param_check
    $error("gsim_solver: illegal parameter set");
  end

  logic [1:0]           state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [1:0]           ph_q, ph_d;
  logic [ITER_W-1:0]    iter_q, iter_d;
  logic [ITER_W-1:0]    sweep_q, sweep_d;
  logic                 out_valid_q, out_valid_d;
  logic [XW-1:0]        x_out_q, x_out_d;
  logic signed [AW-1:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d, bsh_q, bsh_d, acc_q, acc_d;
  logic signed [XW-1:0] res_q, res_d;
  logic signed [AW-1:0] quot_t, rem_t, quot_f;
  logic                 b_we, x_we, x_init, last_sweep;

  logic signed [BW-1:0] b_mem_q [N];
  logic signed [XW-1:0] x_mem_q [N];

`ifdef GSIM_CONVERGE_EN
  localparam logic [XW:0] TOL_W = (XW+1)'(TOL);
  logic signed [XW-1:0] xold_q, xold_d;
  logic                 small_q, small_d, small_now;
  logic [XW:0]          delta, delta_abs;

  assign delta     = {res_q[XW-1], res_q} - {xold_q[XW-1], xold_q};
  assign delta_abs = delta[XW] ? -delta : delta;
  assign small_now = small_q && (delta_abs <= TOL_W);
`endif

  // Neighbours outside 0..N-1 contribute zero.
  function automatic logic signed [XW-1:0] nb(input int j);
    if (j < 0 || j >= N) return '0;
    return x_mem_q[j[IW-1:0]];
  endfunction

  // Exact floor division: truncating quotient corrected down when a negative sum leaves a remainder.
  assign quot_t = acc_q / K20;
  assign rem_t  = acc_q % K20;
  assign quot_f = (acc_q[AW-1] && rem_t != '0) ? quot_t - K1 : quot_t;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    idx_d       = idx_q;
    ph_d        = ph_q;
    iter_d      = iter_q;
    sweep_d     = sweep_q;
    out_valid_d = out_valid_q;
    x_out_d     = x_out_q;
    s1_d        = s1_q;
    s2_d        = s2_q;
    s3_d        = s3_q;
    bsh_d       = bsh_q;
    acc_d       = acc_q;
    res_d       = res_q;
    b_we        = 1'b0;
    x_we        = 1'b0;
    x_init      = 1'b0;
    last_sweep  = 1'b0;
`ifdef GSIM_CONVERGE_EN
    xold_d      = xold_q;
    small_d     = small_q;
`endif
    case (state_q)
      S_RECEIVE: if (in_en) begin
        b_we = 1'b1;
        if (idx_q == '0) iter_d = iter_num;
        if (idx_q == IW'(N-1)) begin
          idx_d   = '0;
          ph_d    = '0;
          sweep_d = '0;
          x_init  = 1'b1;
`ifdef GSIM_CONVERGE_EN
          small_d = 1'b1;
`endif
          if (iter_q == '0) begin
            state_d     = S_SEND;
            out_valid_d = 1'b1;
            x_out_d     = X_ONE;
          end else begin
            state_d = S_CALC;
          end
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_CALC: begin
        ph_d = ph_q + 1'b1;
        case (ph_q)
          2'd0: begin
            s1_d  = AW'(nb(int'(idx_q) - 1)) + AW'(nb(int'(idx_q) + 1));
            s2_d  = AW'(nb(int'(idx_q) - 2)) + AW'(nb(int'(idx_q) + 2));
            s3_d  = AW'(nb(int'(idx_q) - 3)) + AW'(nb(int'(idx_q) + 3));
            bsh_d = AW'(b_mem_q[idx_q]) <<< FW;
`ifdef GSIM_CONVERGE_EN
            xold_d = x_mem_q[idx_q];
`endif
          end
          2'd1: acc_d = bsh_q + K13 * s1_q - K6 * s2_q + s3_q;
          2'd2: begin
            if (quot_f > SAT_HI)      res_d = SAT_HI[XW-1:0];
            else if (quot_f < SAT_LO) res_d = SAT_LO[XW-1:0];
            else                      res_d = quot_f[XW-1:0];
          end
          default: begin
            x_we = 1'b1;
`ifdef GSIM_CONVERGE_EN
            small_d = small_now;
`endif
            if (idx_q == IW'(N-1)) begin
              sweep_d    = sweep_q + 1'b1;
              last_sweep = (sweep_d == iter_q);
`ifdef GSIM_CONVERGE_EN
              last_sweep = last_sweep || small_now;
              small_d    = 1'b1;
`endif
              idx_d = '0;
              if (last_sweep) begin
                state_d     = S_SEND;
                out_valid_d = 1'b1;
                x_out_d     = x_mem_q[0];
              end
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        endcase
      end
      S_SEND: if (out_ready) begin
        if (idx_q == IW'(N-1)) begin
          state_d     = S_RECEIVE;
          idx_d       = '0;
          out_valid_d = 1'b0;
          x_out_d     = '0;
        end else begin
          idx_d   = idx_q + 1'b1;
          x_out_d = x_mem_q[idx_q + 1'b1];
        end
      end
      default: state_d = S_RECEIVE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_RECEIVE;
      idx_q       <= '0;
      ph_q        <= '0;
      iter_q      <= '0;
      sweep_q     <= '0;
      out_valid_q <= 1'b0;
      x_out_q     <= '0;
`ifdef GSIM_CONVERGE_EN
      small_q     <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ph_q        <= ph_d;
      iter_q      <= iter_d;
      sweep_q     <= sweep_d;
      out_valid_q <= out_valid_d;
      x_out_q     <= x_out_d;
`ifdef GSIM_CONVERGE_EN
      small_q     <= small_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    s1_q  <= s1_d;
    s2_q  <= s2_d;
    s3_q  <= s3_d;
    bsh_q <= bsh_d;
    acc_q <= acc_d;
    res_q <= res_d;
`ifdef GSIM_CONVERGE_EN
    xold_q <= xold_d;
`endif
  end

  // NOTE: b/x storage is deliberately not reset; every job rewrites it before it is read.
  always_ff @(posedge clk) begin
    if (b_we) b_mem_q[idx_q] <= b_in;
    if (x_init) begin
      for (int k = 0; k < N; k++) x_mem_q[k] <= X_ONE;
    end else if (x_we) begin
      x_mem_q[idx_q] <= res_q;
    end
  end

  assign busy      = (state_q != S_RECEIVE);
  assign out_valid = out_valid_q;
  assign x_out     = x_out_q;
  assign sweeps    = sweep_q;

endmodule

// File: tb/tb_gsim_solver.sv
// Randomized bench for gsim_solver: N=16, 4 and 64 instances share stimulus, checked against
// a plain-arithmetic Gauss-Seidel model.
module tb_gsim_solver;
  localparam int BW = 16, XW = 32, FW = 16, ITER_W = 8, TOL = 1;
  localparam longint XMAX = 64'sd2147483647;
  localparam longint XMIN = -64'sd2147483648;

  logic                 clk = 1'b0, reset_n = 1'b0, in_en = 1'b0, out_ready = 1'b0;
  logic signed [BW-1:0] b_in = '0;
  logic [ITER_W-1:0]    iter_num = '0;
  int                   sel = 0;

  logic                 busy_v [3];
  logic                 out_valid_v [3];
  logic [XW-1:0]        x_out_v [3];
  logic [ITER_W-1:0]    sweeps_v [3];
  logic                 busy, out_valid;
  logic [XW-1:0]        x_out;
  logic [ITER_W-1:0]    sweeps;

  assign busy      = busy_v[sel];
  assign out_valid = out_valid_v[sel];
  assign x_out     = x_out_v[sel];
  assign sweeps    = sweeps_v[sel];

  always #5 clk = ~clk;

  gsim_solver #(.N(16), .BW(BW), .XW(XW), .FW(FW), .ITER_W(ITER_W), .TOL(TOL)) dut16 (
    .clk(clk), .reset_n(reset_n), .in_en(in_en && sel == 0), .b_in(b_in), .iter_num(iter_num),
    .busy(busy_v[0]), .out_valid(out_valid_v[0]), .out_ready(out_ready && sel == 0),
    .x_out(x_out_v[0]), .sweeps(sweeps_v[0]));
  gsim_solver #(.N(4), .BW(BW), .XW(XW), .FW(FW), .ITER_W(ITER_W), .TOL(TOL)) dut4 (
    .clk(clk), .reset_n(reset_n), .in_en(in_en && sel == 1), .b_in(b_in), .iter_num(iter_num),
    .busy(busy_v[1]), .out_valid(out_valid_v[1]), .out_ready(out_ready && sel == 1),
    .x_out(x_out_v[1]), .sweeps(sweeps_v[1]));
  gsim_solver #(.N(64), .BW(BW), .XW(XW), .FW(FW), .ITER_W(ITER_W), .TOL(TOL)) dut64 (
    .clk(clk), .reset_n(reset_n), .in_en(in_en && sel == 2), .b_in(b_in), .iter_num(iter_num),
    .busy(busy_v[2]), .out_valid(out_valid_v[2]), .out_ready(out_ready && sel == 2),
    .x_out(x_out_v[2]), .sweeps(sweeps_v[2]));

  int          total = 0, bad = 0;
  longint      b_arr [64];
  longint      mx [64];
  longint      exp_x [64];
  logic [XW-1:0] rx [64];
  int          exp_sw;

  function automatic int n_of(input int s);
    return (s == 0) ? 16 : (s == 1) ? 4 : 64;
  endfunction

  function automatic longint xg(input int j, input int n);
    if (j < 0 || j >= n) return 0;
    return mx[j];
  endfunction

  task automatic fill_b(input int n, input bit rnd);
    for (int i = 0; i < n; i++)
      b_arr[i] = rnd ? longint'($urandom_range(0, 65535)) - 32768 : 0;
  endtask

  // Reference: sweeps of x_i = floor((b_i*2^FW + 13(..) - 6(..) + (..)) / 20), saturated to int32.
  task automatic model(input int n, input int iter);
    longint s, q, d, maxd;
    for (int i = 0; i < n; i++) mx[i] = 64'sd65536;
    exp_sw = 0;
    for (int k = 0; k < iter; k++) begin
      maxd = 0;
      for (int i = 0; i < n; i++) begin
        s = b_arr[i] * 65536 + 13 * (xg(i-1, n) + xg(i+1, n)) - 6 * (xg(i-2, n) + xg(i+2, n))
            + xg(i-3, n) + xg(i+3, n);
        q = s / 20;
        if (s < 0 && s % 20 != 0) q = q - 1;
        if (q > XMAX) q = XMAX;
        if (q < XMIN) q = XMIN;
        d = q - mx[i];
        if (d < 0) d = -d;
        if (d > maxd) maxd = d;
        mx[i] = q;
      end
      exp_sw++;
`ifdef GSIM_CONVERGE_EN
      if (maxd <= TOL) break;
`endif
    end
    for (int i = 0; i < n; i++) exp_x[i] = mx[i];
  endtask

  task automatic send_job(input int n, input int iter, input bit gaps);
    for (int k = 0; k < n; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_en = 1'b0;
        b_in  = BW'($urandom);
        @(negedge clk);
      end
      in_en    = 1'b1;
      b_in     = BW'(b_arr[k]);
      iter_num = (k == 0) ? ITER_W'(iter) : ITER_W'($urandom);
      @(negedge clk);
    end
    in_en = 1'b0;
  endtask

  task automatic recv_words(input string name, input int n, input bit bp);
    int got = 0, guard = 0;
    bit stalled = 1'b0;
    logic [XW-1:0] held = '0;
    while (got < n && guard < 5000) begin
      if (out_valid !== 1'b1) begin
        total++; bad++;
        $display("FAIL %s valid_drop: out_valid=%b after %0d words, required 1", name, out_valid, got);
        break;
      end
      if (stalled) begin
        total++;
        if (x_out !== held) begin
          bad++;
          $display("FAIL %s stall_hold: x_out=%h, required %h", name, x_out, held);
        end
      end
      out_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (out_ready) begin
        rx[got] = x_out;
        got++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held    = x_out;
      end
      @(negedge clk);
      guard++;
    end
    out_ready = 1'b0;
    total++;
    if (got !== n) begin
      bad++;
      $display("FAIL %s transfers: got %0d, required %0d", name, got, n);
    end
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s end_idle: out_valid=%b busy=%b, required 0 0", name, out_valid, busy);
    end
  endtask

  task automatic run_job(input string name, input int iter, input bit gaps, input bit bp);
    int n = n_of(sel);
    int cyc = 0;
    model(n, iter);
    send_job(n, iter, gaps);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL %s busy: busy=%b after last word, required 1", name, busy);
    end
    while (out_valid !== 1'b1 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (cyc != 4 * n * exp_sw) begin
      bad++;
      $display("FAIL %s latency: %0d cycles to out_valid, required %0d", name, cyc, 4 * n * exp_sw);
    end
    if (out_valid !== 1'b1) return;
    total++;
    if (sweeps !== ITER_W'(exp_sw)) begin
      bad++;
      $display("FAIL %s sweeps: got %0d, required %0d", name, sweeps, exp_sw);
    end
    recv_words(name, n, bp);
    for (int k = 0; k < n; k++) begin
      logic [63:0] e = exp_x[k];
      total++;
      if (rx[k] !== e[XW-1:0]) begin
        bad++;
        $display("FAIL %s x[%0d]: got %h, required %h", name, k, rx[k], e[XW-1:0]);
      end
    end
  endtask

  task automatic pulse_reset(input string name);
    reset_n   = 1'b0;
    in_en     = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || x_out !== '0 || sweeps !== '0) begin
      bad++;
      $display("FAIL %s reset_state: valid=%b busy=%b x_out=%h sweeps=%0d, required 0 0 0 0",
               name, out_valid, busy, x_out, sweeps);
    end
  endtask

  task automatic test_reset();
    sel = 0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    pulse_reset("reset");
  endtask

  task automatic test_one_sweep();
    sel = 0;
    fill_b(16, 1'b0);
    run_job("one_sweep", 1, 1'b0, 1'b0);
    total++;
    if (rx[0] !== 32'd26214) begin
      bad++;
      $display("FAIL one_sweep x0: got %0d, required 26214", rx[0]);
    end
  endtask

  task automatic test_iter_zero();
    sel = 0;
    fill_b(16, 1'b1);
    run_job("iter_zero", 0, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      total++;
      if (rx[k] !== 32'h0001_0000) begin
        bad++;
        $display("FAIL iter_zero word%0d: got %h, required 00010000", k, rx[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      fill_b(n_of(s), 1'b1);
      run_job($sformatf("random_n%0d", n_of(s)), 70, 1'b1, 1'b0);
    end
    sel = 0;
  endtask

  task automatic test_backpressure();
    sel = 0;
    for (int r = 0; r < 2; r++) begin
      fill_b(16, 1'b1);
      run_job("backpressure", 3 + r, 1'b1, 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    sel = 1;
    fill_b(4, 1'b1);
    run_job("b2b_first", 2, 1'b0, 1'b0);
    fill_b(4, 1'b1);
    run_job("b2b_second", 5, 1'b0, 1'b0);
    sel = 0;
  endtask

  task automatic test_reset_mid_calc();
    sel = 0;
    fill_b(16, 1'b1);
    send_job(16, 5, 1'b0);
    repeat (37) @(negedge clk);
    pulse_reset("mid_calc");
    fill_b(16, 1'b1);
    run_job("after_calc_reset", 3, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_send();
    int cyc = 0;
    sel = 0;
    fill_b(16, 1'b1);
    send_job(16, 1, 1'b0);
    while (out_valid !== 1'b1 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    out_ready = 1'b0;
    pulse_reset("mid_send");
    fill_b(16, 1'b1);
    run_job("after_send_reset", 2, 1'b0, 1'b1);
  endtask

  task automatic test_converge();
    sel = 0;
    fill_b(16, 1'b0);
    run_job("converge", 255, 1'b0, 1'b0);
    total++;
`ifdef GSIM_CONVERGE_EN
    if (sweeps_v[0] >= 8'd255) begin
      bad++;
      $display("FAIL converge early_stop: sweeps=%0d, required < 255", sweeps_v[0]);
    end
    for (int k = 0; k < 16; k++) begin
      int v = $signed(rx[k]);
      total++;
      if (v > 16 || v < -16) begin
        bad++;
        $display("FAIL converge bound x[%0d]: got %0d, required |x| <= 16", k, v);
      end
    end
`else
    if (sweeps_v[0] !== 8'd255) begin
      bad++;
      $display("FAIL converge full_run: sweeps=%0d, required 255", sweeps_v[0]);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_one_sweep();
    test_iter_zero();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_calc();
    test_reset_mid_send();
    test_converge();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
